jtcps1_scroll_sched: RTL

Per-line sequencer for the three scroll tilemap engines (scroll1 8x8, scroll2 16x16, scroll3 32x32).
- On each line request it runs the enabled layers one at a time, in order 0, 1, 2.
- It shares the single VRAM read port and the single GFX ROM read port with whichever layer is active.
- It sits between the video timing logic and the tilemap engines, ahead of the SDRAM arbiter.

---
 rtl/jtcps1_scroll_sched_pkg.sv | 27 ++
 rtl/jtcps1_scroll_sched_if.sv | 31 +++
 rtl/jtcps1_scroll_sched_mux.sv | 30 +++
 rtl/jtcps1_scroll_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/jtcps1_scroll_sched_pkg.sv
// Shared types and constants for the scroll-layer line scheduler.
package jtcps1_sched_pkg;

  localparam int unsigned NLAYER = 3;
  localparam int unsigned L_SCR1 = 0;
  localparam int unsigned L_SCR2 = 1;
  localparam int unsigned L_SCR3 = 2;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    ARM,
    RUN,
    FIN
  } sched_state_e;

  typedef logic [1:0] layer_sel_t;

  // Index of the lowest set bit; L_SCR1 when the mask is empty.
  function automatic layer_sel_t lowest_set(input logic [NLAYER-1:0] m);
    lowest_set = layer_sel_t'(L_SCR1);
    for (int unsigned i = NLAYER; i > 0; i--) begin
      if (m[i-1]) lowest_set = layer_sel_t'(i - 1);
    end
  endfunction

endpackage

// File: rtl/jtcps1_scroll_sched_if.sv
// Per-layer and shared VRAM/ROM request buses around the scroll scheduler.
interface jtcps1_scroll_sched_if #(
  parameter int unsigned AW_VRAM = 24,
  parameter int unsigned AW_ROM  = 22
);
  import jtcps1_sched_pkg::*;

  logic [NLAYER*AW_VRAM-1:0] l_vram_addr;
  logic [NLAYER-1:0]         l_vram_cs;
  logic [NLAYER-1:0]         l_vram_ok;
  logic [NLAYER*AW_ROM-1:0]  l_rom_addr;
  logic [NLAYER-1:0]         l_rom_cs;
  logic [NLAYER-1:0]         l_rom_ok;
  logic [AW_VRAM-1:0]        vram_addr;
  logic                      vram_cs;
  logic                      vram_ok;
  logic [AW_ROM-1:0]         rom_addr;
  logic                      rom_cs;
  logic                      rom_ok;

  modport master (
    input  l_vram_addr, l_vram_cs, l_rom_addr, l_rom_cs, vram_ok, rom_ok,
    output l_vram_ok, l_rom_ok, vram_addr, vram_cs, rom_addr, rom_cs
  );

  modport slave (
    output l_vram_addr, l_vram_cs, l_rom_addr, l_rom_cs, vram_ok, rom_ok,
    input  l_vram_ok, l_rom_ok, vram_addr, vram_cs, rom_addr, rom_cs
  );

endinterface

// File: rtl/jtcps1_scroll_sched_mux.sv
// Combinational steering of one shared read port to the selected layer.
module jtcps1_sched_mux
  import jtcps1_sched_pkg::*;
#(
  parameter int unsigned AW = 24
) (
  input  layer_sel_t          sel_i,
  input  logic                run_i,
  input  logic [NLAYER*AW-1:0] l_addr_i,
  input  logic [NLAYER-1:0]   l_cs_i,
  output logic [AW-1:0]       addr_o,
  output logic                cs_o,
  input  logic                ok_i,
  output logic [NLAYER-1:0]   l_ok_o
);

  always_comb begin
    addr_o = '0;
    cs_o   = 1'b0;
    l_ok_o = '0;
    for (int unsigned i = 0; i < NLAYER; i++) begin
      if (sel_i == layer_sel_t'(i)) begin
        addr_o    = l_addr_i[i*AW +: AW];
        cs_o      = l_cs_i[i] & run_i;
        l_ok_o[i] = ok_i & run_i;
      end
    end
  end

endmodule

// File: rtl/jtcps1_scroll_sched.sv
// Per-line sequencer running scroll1/2/3 in turn over shared VRAM and ROM ports.
// Optional watchdog on ARM/RUN enabled by JTCPS1_SCHED_WATCHDOG_EN.
module jtcps1_scroll_sched
  import jtcps1_sched_pkg::*;
#(
  parameter int unsigned AW_VRAM = 24,
  parameter int unsigned AW_ROM  = 22
`ifdef JTCPS1_SCHED_WATCHDOG_EN
  , parameter int unsigned TIMEOUT = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic [8:0] vrender,
  input  logic [2:0] layer_en,
  output logic [8:0] v,
  output logic [2:0] start,
  input  logic [2:0] done,
  output logic       buf_sel,
  output logic       busy,
  output logic       line_done,
  output logic       overrun,
`ifdef JTCPS1_SCHED_WATCHDOG_EN
  output logic [2:0] wd_err,
`endif
  jtcps1_scroll_sched_if.master bus
);

  sched_state_e      state_q, state_d;
  layer_sel_t        sel_q, sel_d;
  logic [NLAYER-1:0] mask_q, mask_d, ran_q, ran_d;
  logic              pend_q, pend_d;
  logic [8:0]        pend_v_q, pend_v_d;
  logic [NLAYER-1:0] pend_mask_q, pend_mask_d;
  logic [8:0]        v_q, v_d;
  logic              buf_q, buf_d;
  logic [NLAYER-1:0] start_q, start_d;
  logic              busy_q, busy_d;
  logic              ldone_q, ldone_d;
  logic              ovr_q, ovr_d;
  logic              launch, run, wd_hit;
  logic [NLAYER-1:0] remain, sel_oh;
  logic              done_sel;

  assign remain   = mask_q & ~ran_q;
  assign sel_oh   = {{(NLAYER-1){1'b0}}, 1'b1} << sel_q;
  assign done_sel = |(done & sel_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      mask_q      <= '0;
      ran_q       <= '0;
      pend_q      <= 1'b0;
      pend_v_q    <= '0;
      pend_mask_q <= '0;
      v_q         <= '0;
      buf_q       <= 1'b0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      ldone_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      ran_q       <= ran_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      pend_mask_q <= pend_mask_d;
      v_q         <= v_d;
      buf_q       <= buf_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      ldone_q     <= ldone_d;
      ovr_q       <= ovr_d;
    end
  end

  // A line is launched either from the inputs (IDLE) or from the pending slot,
  // which lets FIN chain straight into SEEK without an IDLE cycle.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mask_d      = mask_q;
    ran_d       = ran_q;
    v_d         = v_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;
    pend_mask_d = pend_mask_q;
    launch      = 1'b0;
    if (line_start && !pend_q && state_q != IDLE) begin
      pend_d      = 1'b1;
      pend_v_d    = vrender;
      pend_mask_d = layer_en;
    end
    unique case (state_q)
      IDLE: launch = pend_q | line_start;
      SEEK: begin
        if (|remain) begin
          sel_d   = lowest_set(remain);
          state_d = ARM;
        end else begin
          state_d = FIN;
        end
      end
      ARM: begin
        if (wd_hit) begin
          ran_d   = ran_q | sel_oh;
          state_d = SEEK;
        end else if (!done_sel) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (wd_hit || done_sel) begin
          ran_d   = ran_q | sel_oh;
          state_d = SEEK;
        end
      end
      FIN: begin
        launch  = pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = SEEK;
      ran_d   = '0;
      buf_d   = ~buf_q;
      pend_d  = 1'b0;
      v_d     = pend_q ? pend_v_q : vrender;
      mask_d  = pend_q ? pend_mask_q : layer_en;
    end
  end

  always_comb begin
    start_d = start_q;
    if (state_q == ARM && state_d == RUN) start_d = sel_oh;
    if ((state_q == ARM || state_q == RUN) && state_d == SEEK) start_d = '0;
    busy_d  = (state_d != IDLE);
    ldone_d = (state_q == FIN);
    ovr_d   = line_start & pend_q;
    run     = (state_q == RUN);
  end

`ifdef JTCPS1_SCHED_WATCHDOG_EN
  localparam int unsigned WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;
  logic [NLAYER-1:0] wd_err_q, wd_err_d;

  assign wd_hit = (state_q == ARM || state_q == RUN) &&
                  (wd_cnt_q == WDW'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q;
    if (state_q == ARM || state_q == RUN) wd_cnt_d = wd_cnt_q + 1'b1;
    if (state_d == ARM && state_q != ARM) wd_cnt_d = '0;
    if (wd_hit) wd_err_d = wd_err_q | sel_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      wd_err_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_hit = 1'b0;
`endif

  assign v         = v_q;
  assign start     = start_q;
  assign buf_sel   = buf_q;
  assign busy      = busy_q;
  assign line_done = ldone_q;
  assign overrun   = ovr_q;

  jtcps1_sched_mux #(.AW(AW_VRAM)) u_vram_mux (
    .sel_i    (sel_q),
    .run_i    (run),
    .l_addr_i (bus.l_vram_addr),
    .l_cs_i   (bus.l_vram_cs),
    .addr_o   (bus.vram_addr),
    .cs_o     (bus.vram_cs),
    .ok_i     (bus.vram_ok),
    .l_ok_o   (bus.l_vram_ok)
  );

  jtcps1_sched_mux #(.AW(AW_ROM)) u_rom_mux (
    .sel_i    (sel_q),
    .run_i    (run),
    .l_addr_i (bus.l_rom_addr),
    .l_cs_i   (bus.l_rom_cs),
    .addr_o   (bus.rom_addr),
    .cs_o     (bus.rom_cs),
    .ok_i     (bus.rom_ok),
    .l_ok_o   (bus.l_rom_ok)
  );

endmodule
